// File: rtl/regfile_hilo_pkg.sv
// Shared bus widths, field positions and decoded write-request structs for the
// write-back to register-file interface.
package regfile_hilo_pkg;

  localparam int WB_TO_RF_WD = 38;
  localparam int HILO_BUS_WD = 65;

  localparam int RF_WE_BIT    = 37;
  localparam int RF_WADDR_HI  = 36;
  localparam int RF_WADDR_LO  = 32;
  localparam int RF_WDATA_HI  = 31;

  localparam int HILO_WE_BIT  = 64;
  localparam int HILO_HI_HI   = 63;
  localparam int HILO_HI_LO   = 32;
  localparam int HILO_LO_HI   = 31;

  localparam int BUS_DW = 32;

  typedef struct packed {
    logic              we;
    logic [4:0]        waddr;
    logic [BUS_DW-1:0] wdata;
  } rf_wr_t;

  typedef struct packed {
    logic              we;
    logic [BUS_DW-1:0] hi;
    logic [BUS_DW-1:0] lo;
  } hilo_wr_t;

endpackage

// File: rtl/regfile_hilo_hilo_reg.sv
// HI/LO register pair with optional same-cycle write-through.
// Build option: REGFILE_BYPASS_EN enables the write-through mux.
module hilo_reg #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          we,
  input  logic [DW-1:0] hi,
  input  logic [DW-1:0] lo,
  output logic [DW-1:0] hi_rdata,
  output logic [DW-1:0] lo_rdata
);

  logic [DW-1:0] hi_q, lo_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (we) begin
      hi_q <= hi;
      lo_q <= lo;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign hi_rdata = we ? hi : hi_q;
  assign lo_rdata = we ? lo : lo_q;
`else
  assign hi_rdata = hi_q;
  assign lo_rdata = lo_q;
`endif

endmodule

// File: rtl/regfile_hilo.sv
// MIPS GPR file + HI/LO + retired-write counter, fed by the WB-stage buses.
// Build option: REGFILE_BYPASS_EN makes reads see same-cycle writes.
module regfile_hilo
  import regfile_hilo_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int DW    = 32,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [WB_TO_RF_WD-1:0] wb_to_rf_bus,
  input  logic [HILO_BUS_WD-1:0] wb_to_id_hilo,
  input  logic [4:0]             raddr1,
  input  logic [4:0]             raddr2,
  output logic [DW-1:0]          rdata1,
  output logic [DW-1:0]          rdata2,
  output logic [DW-1:0]          hi_rdata,
  output logic [DW-1:0]          lo_rdata,
  output logic [CNT_W-1:0]       wr_count
);

  rf_wr_t   rf_wr;
  hilo_wr_t hl_wr;
  logic     gpr_we;

  assign rf_wr.we    = wb_to_rf_bus[RF_WE_BIT];
  assign rf_wr.waddr = wb_to_rf_bus[RF_WADDR_HI:RF_WADDR_LO];
  assign rf_wr.wdata = wb_to_rf_bus[RF_WDATA_HI:0];
  assign hl_wr.we    = wb_to_id_hilo[HILO_WE_BIT];
  assign hl_wr.hi    = wb_to_id_hilo[HILO_HI_HI:HILO_HI_LO];
  assign hl_wr.lo    = wb_to_id_hilo[HILO_LO_HI:0];

  // Writes to r0 are dropped here, so gpr[0] stays at its reset value of 0.
  assign gpr_we = rf_wr.we && (rf_wr.waddr != 5'd0);

  logic [DW-1:0] gpr [NREG];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
    end else if (gpr_we) begin
      gpr[rf_wr.waddr] <= rf_wr.wdata;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign rdata1 = (gpr_we && raddr1 == rf_wr.waddr) ? rf_wr.wdata : gpr[raddr1];
  assign rdata2 = (gpr_we && raddr2 == rf_wr.waddr) ? rf_wr.wdata : gpr[raddr2];
`else
  assign rdata1 = gpr[raddr1];
  assign rdata2 = gpr[raddr2];
`endif

  hilo_reg #(.DW(DW)) u_hilo (
    .clk      (clk),
    .resetn   (resetn),
    .we       (hl_wr.we),
    .hi       (hl_wr.hi),
    .lo       (hl_wr.lo),
    .hi_rdata (hi_rdata),
    .lo_rdata (lo_rdata)
  );

  // Both commits on one edge count twice; wraps silently.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) wr_count <= '0;
    else         wr_count <= wr_count + CNT_W'(gpr_we) + CNT_W'(hl_wr.we);
  end

endmodule
